// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority event encoder.
package prio_enc_pkg;

    localparam int PRIO_N_DEFAULT = 8;
    localparam int PRIO_N_MIN     = 2;
    localparam int PRIO_N_MAX     = 32;

    // Ceiling log2, never below 1 so a 2-input encoder still gets an index bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational N-to-W priority encoder. Searches base-1, base-2, ... modulo N,
// with base itself searched last; base = 0 gives plain highest-index-wins.
module prio_enc_comb
    import prio_enc_pkg::*;
#(
    parameter int N = PRIO_N_DEFAULT,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] base_i,
    output logic [W-1:0] index_o,
    output logic         any_o
);

    logic [W-1:0] pos;
    logic         found;

    always_comb begin
        index_o = '0;
        any_o   = 1'b0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 1; k <= N; k++) begin
            pos = W'((int'(base_i) + N - k) % N);
            if (!found && vec_i[pos]) begin
                found   = 1'b1;
                any_o   = 1'b1;
                index_o = pos;
            end
        end
    end

endmodule

// File: rtl/prio_event_encoder.sv
// Pending-event register with a registered valid/ready offer of the top-priority event.
// Define PRIO_EVENT_ENCODER_ROTATE_EN to rotate priority past the last accepted index.
module prio_event_encoder
    import prio_enc_pkg::*;
#(
    parameter int N = PRIO_N_DEFAULT,
    localparam int W = clog2(N)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req_in,
    input  logic         clear_all,
    output logic         out_valid,
    output logic [W-1:0] out_index,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    if (N < PRIO_N_MIN || N > PRIO_N_MAX) begin : g_bad_n
        $error("prio_event_encoder: N out of range");
    end

    logic [N-1:0] pending_q, pending_d;
    logic         valid_q, valid_d;
    logic [W-1:0] index_q, index_d;
    logic         ovf_q, ovf_d;
    logic         accept;
    logic [N-1:0] served;
    logic [W-1:0] base;
    logic [W-1:0] enc_idx;
    logic         enc_any;

    assign accept = valid_q & out_ready;
    assign served = accept ? (N'(1) << index_q) : '0;

`ifdef PRIO_EVENT_ENCODER_ROTATE_EN
    logic [W-1:0] last_q, last_d;
    // The index accepted this cycle already counts as "last" for the reload search.
    assign last_d = accept ? index_q : last_q;
    assign base   = last_d;

    always_ff @(posedge clock) begin
        if (!reset_n)       last_q <= '0;
        else if (!clear_all) last_q <= last_d;
    end
`else
    assign base = '0;
`endif

    prio_enc_comb #(.N(N)) u_enc (
        .vec_i   (pending_d),
        .base_i  (base),
        .index_o (enc_idx),
        .any_o   (enc_any)
    );

    always_comb begin
        pending_d = (pending_q & ~served) | req_in;
        ovf_d     = ovf_q | (|(req_in & pending_q & ~served));
        valid_d   = valid_q;
        index_d   = index_q;
        // A stalled offer stays frozen even if a higher-priority event arrives.
        if (!valid_q || out_ready) begin
            valid_d = enc_any;
            index_d = enc_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear_all) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_index = index_q;
    assign pending   = pending_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench for prio_event_encoder (N=8) with a per-cycle expectation queue.
module tb_prio_event_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req_in = 8'hFF;
    logic         clear_all = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_index;
    logic [N-1:0] pending;
    logic         overflow;

    typedef struct packed {
        logic         v;
        logic [W-1:0] idx;
        logic [N-1:0] pend;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    prio_event_encoder #(.N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_in    (req_in),
        .clear_all (clear_all),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the edge, then check.
    task automatic step(input string tag, input logic rst_n, input logic [N-1:0] req,
                        input logic rdy, input logic clr, input logic ev, input int eidx,
                        input logic [N-1:0] ep, input logic eo);
        exp_t e;
        reset_n   = rst_n;
        req_in    = req;
        out_ready = rdy;
        clear_all = clr;
        e.v    = ev;
        e.idx  = W'(eidx);
        e.pend = ep;
        e.ovf  = eo;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        cmp({tag, ".valid"},   32'(out_valid), 32'(e.v));
        cmp({tag, ".index"},   32'(out_index), 32'(e.idx));
        cmp({tag, ".pending"}, 32'(pending),   32'(e.pend));
        cmp({tag, ".ovf"},     32'(overflow),  32'(e.ovf));
    endtask

    initial begin
        int ei;
        // reset held for two edges with all requests asserted
        step("rst0", 0, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        step("rst1", 0, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        step("rst_first", 1, 8'hFF, 0, 0, 1, 7, 8'hFF, 0);
        step("rst_hold", 1, 8'h00, 0, 0, 1, 7, 8'hFF, 0);
        step("rst2", 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        // burst drains highest first, back to back
        step("burst0", 1, 8'hCC, 1, 0, 1, 7, 8'hCC, 0);
        step("burst1", 1, 8'h00, 1, 0, 1, 6, 8'h4C, 0);
        step("burst2", 1, 8'h00, 1, 0, 1, 3, 8'h0C, 0);
        step("burst3", 1, 8'h00, 1, 0, 1, 2, 8'h04, 0);
        step("burst4", 1, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        step("burst5", 1, 8'h00, 1, 0, 0, 0, 8'h00, 0);

        // backpressure keeps the offer frozen at 2
        step("bp0", 1, 8'h04, 0, 0, 1, 2, 8'h04, 0);
        step("bp1", 1, 8'h80, 0, 0, 1, 2, 8'h84, 0);
        step("bp2", 1, 8'h00, 0, 0, 1, 2, 8'h84, 0);
        step("bp3", 1, 8'h00, 1, 0, 1, 7, 8'h80, 0);
        step("bp4", 1, 8'h00, 1, 0, 0, 0, 8'h00, 0);

        // re-arm on the served index is not an overflow
        step("rearm0", 1, 8'h02, 0, 0, 1, 1, 8'h02, 0);
        step("rearm1", 1, 8'h02, 1, 0, 1, 1, 8'h02, 0);
        step("rearm2", 1, 8'h00, 1, 0, 0, 0, 8'h00, 0);

        // second request on a still-pending bit is lost
        step("ovf0", 1, 8'h08, 0, 0, 1, 3, 8'h08, 0);
        step("ovf1", 1, 8'h08, 0, 0, 1, 3, 8'h08, 1);
        step("ovf2", 1, 8'h00, 1, 0, 0, 0, 8'h00, 1);
        step("ovf3", 1, 8'h00, 1, 0, 0, 0, 8'h00, 1);

        // flush beats new requests and the accept in the same cycle
        step("flush0", 1, 8'h30, 0, 0, 1, 5, 8'h30, 1);
        step("flush1", 1, 8'hFF, 1, 1, 0, 0, 8'h00, 0);
        step("flush2", 1, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        // saturated requests: rotation order or fixed 7
        step("rst3", 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        for (int k = 1; k <= 9; k++) begin
`ifdef PRIO_EVENT_ENCODER_ROTATE_EN
            ei = (k == 9) ? 7 : 8 - k;
`else
            ei = 7;
`endif
            step($sformatf("rot%0d", k), 1, 8'hFF, 1, 0, 1, ei, 8'hFF, k > 1);
        end

        // reset during a live offer drops it
        step("rst4", 0, 8'hFF, 1, 0, 0, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
